// File: rtl/alu32_pkg.sv
// Shared constants, state type and helpers for the 32-bit sequential divider.
package alu32_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned DIV_STEPS   = 32;
  localparam int unsigned DIV_LATENCY = 34;
  localparam int unsigned CNT_W       = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Magnitude of v when signed operation is requested; 0x80000000 stays 0x80000000.
  function automatic logic [WIDTH-1:0] abs_if(input logic en, input logic [WIDTH-1:0] v);
    return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module div_step
  import alu32_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign shifted    = {rem_i, bit_i};
  assign diff       = {1'b0, shifted} - {2'b00, divisor_i};
  assign borrow     = diff[WIDTH+1];
  assign quot_bit_o = ~borrow;
  // Partial remainder stays below the divisor, so the upper bits are always zero here.
  assign rem_o      = WIDTH'(borrow ? {1'b0, shifted} : diff);

endmodule

// File: rtl/div_32_seq.sv
// Sequential 32-bit signed/unsigned divider: 32 restoring steps plus a sign fix-up cycle.
module div_32_seq
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = alu32_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step u_step (
    .rem_i      (rem_q),
    .divisor_i  (dvsr_q),
    .bit_i      (q_q[WIDTH-1]),
    .rem_o      (step_rem),
    .quot_bit_o (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    raw_d   = raw_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_q_d = sign_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = sign_op & dividend[WIDTH-1];
          q_d     = abs_if(sign_op, dividend);
          dvsr_d  = abs_if(sign_op, divisor);
          raw_d   = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // A zero divisor overrides the (meaningless) step results with the fixed convention.
        if (dvsr_q == '0) begin
          quot_d = '1;
          remo_d = raw_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = neg_q_q ? (~q_q + 1'b1) : q_q;
          remo_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
          dz_d   = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      raw_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      raw_q   <= raw_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// Randomized self-checking bench for div_32_seq against an arithmetic reference model.
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  div_32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_op   (sign_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end
  endtask

  // Counts negedges (starting at 1) until done is seen; gives up at 45.
  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 45) begin
      @(negedge clk);
      k++;
    end
  endtask

  // mode 0: plain; mode 1: extra start mid-CALC; mode 2: reset mid-CALC.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] eq, er;
    logic        ez;
    int          k;
    model(s, a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1; sign_op = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; sign_op = ~s; dividend = $urandom; divisor = $urandom;
    check("busy_after_accept", 32'(busy), 32'd1);
    k = 1;
    while (!done && k < 45) begin
      if (mode == 1 && k == 5) begin
        start = 1'b1; dividend = $urandom; divisor = 32'd3; sign_op = $urandom_range(0, 1);
      end
      if (mode == 1 && k == 6) start = 1'b0;
      if (mode == 2 && k == 10) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (done) check("no_done_after_rst", 32'(done), 32'd0);
        end
        check("idle_after_rst", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
      k++;
    end
    check("latency", k, 34);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", 32'(ez), 32'(div_zero));
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("quot_held", quotient, eq);
  endtask

  // start held through the DONE cycle must only be accepted in the following IDLE cycle.
  task automatic b2b();
    logic [31:0] eq, er;
    logic        ez;
    int          k, j;
    @(negedge clk);
    start = 1'b1; sign_op = 1'b0; dividend = 32'd1000; divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    check("b2b_first_latency", k, 34);
    check("b2b_first_quot", quotient, 32'd111);
    start = 1'b1; sign_op = 1'b0; dividend = 32'd77; divisor = 32'd5;
    model(1'b1, 32'hFFFF_FF00, 32'd7, eq, er, ez);
    j = 0;
    while (!(done && j > 0) && j < 45) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        sign_op = 1'b1; dividend = 32'hFFFF_FF00; divisor = 32'd7;
      end
      if (j == 2) start = 1'b0;
    end
    check("b2b_spacing", j, 35);
    check("b2b_quot", quotient, eq);
    check("b2b_rem", remainder, er);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quot", quotient, 32'd0);
    check("reset_rem", remainder, 32'd0);
    check("reset_dz", 32'(div_zero), 32'd0);
    // rst wins over a simultaneous start
    start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(negedge clk);
    check("rst_over_start", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;

    do_op(1'b0, 32'd100, 32'd7, 0);
    check("ref_100_7_q", quotient, 32'd14);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    check("ref_m7_2_r", remainder, 32'hFFFF_FFFF);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    check("ref_7_m2_q", quotient, 32'hFFFF_FFFD);
    do_op(1'b0, 32'd5, 32'd0, 0);
    do_op(1'b1, 32'd5, 32'd0, 0);
    check("ref_5_0_rem", remainder, 32'd5);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ref_min_m1_q", quotient, 32'h8000_0000);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1'b1, 32'h8000_0000, 32'd0, 0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);

    do_op(1'b0, 32'd12345, 32'd17, 1);
    check("ignored_start_q", quotient, 32'd726);
    do_op(1'b1, 32'hDEAD_BEEF, 32'd77, 2);
    do_op(1'b0, 32'd4000, 32'd33, 0);

    b2b();

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = $urandom;
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = ~($urandom >> $urandom_range(0, 31));
      endcase
      do_op(s, a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
